// File: rtl/adventure_maze.sv
// Grid-of-rooms adventure game core: walk N/S/E/W, pick up the sword, face the dragon.
// Optional move-budget death is enabled by defining ADV_MOVE_LIMIT_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// PLAY    | accepting single-direction moves
// RESPAWN | one cycle showing the dragon room after losing a life
// WON     | dragon slain with the sword; everything frozen until reset
// DEAD    | out of lives (or out of moves); everything frozen until reset
module adventure_maze #(
   parameter int GRID_W      = 4,
   parameter int GRID_H      = 4,
   parameter int START_ROOM  = 0,
   parameter int SWORD_ROOM  = 5,
   parameter int DRAGON_ROOM = 15,
   parameter int LIVES       = 3,
   parameter int MOVE_LIMIT  = 31,
   localparam int RW = $clog2(GRID_W * GRID_H),
   localparam int MW = $clog2(MOVE_LIMIT + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          N,
   input  logic          S,
   input  logic          E,
   input  logic          W,
   output logic [RW-1:0] room,
   output logic          has_sword,
   output logic [2:0]    lives,
   output logic [MW-1:0] moves,
   output logic          WIN,
   output logic          DIE
);

   localparam int CW = $clog2(GRID_W);
   localparam int HW = $clog2(GRID_H);

   localparam logic [HW-1:0] START_ROW = HW'(START_ROOM / GRID_W);
   localparam logic [CW-1:0] START_COL = CW'(START_ROOM % GRID_W);
   localparam logic [HW-1:0] LAST_ROW  = HW'(GRID_H - 1);
   localparam logic [CW-1:0] LAST_COL  = CW'(GRID_W - 1);
   localparam logic [RW-1:0] START_R   = RW'(START_ROOM);
   localparam logic [RW-1:0] SWORD_R   = RW'(SWORD_ROOM);
   localparam logic [RW-1:0] DRAGON_R  = RW'(DRAGON_ROOM);
   localparam logic [MW-1:0] LIMIT_M   = MW'(MOVE_LIMIT);

   typedef enum logic [1:0] {PLAY, RESPAWN, WON, DEAD} state_t;

   state_t        r_state;
   logic [HW-1:0] r_row;
   logic [CW-1:0] r_col;
   logic [RW-1:0] r_room;
   logic          r_sword;
   logic [2:0]    r_lives;
   logic [MW-1:0] r_moves;
   logic          r_win;
   logic          r_die;

   logic          w_ok;
   logic [HW-1:0] w_tgt_row;
   logic [CW-1:0] w_tgt_col;
   logic [RW-1:0] w_tgt_room;
   logic [MW-1:0] w_moves_nx;
   logic          w_at_dragon;

   // Target room for a single, wall-checked move request.
   always_comb begin
      w_ok      = 1'b0;
      w_tgt_row = r_row;
      w_tgt_col = r_col;
      if ($onehot({N, S, E, W})) begin
         if (N && r_row != '0) begin
            w_tgt_row = r_row - HW'(1);
            w_ok      = 1'b1;
         end
         if (S && r_row != LAST_ROW) begin
            w_tgt_row = r_row + HW'(1);
            w_ok      = 1'b1;
         end
         if (E && r_col != LAST_COL) begin
            w_tgt_col = r_col + CW'(1);
            w_ok      = 1'b1;
         end
         if (W && r_col != '0) begin
            w_tgt_col = r_col - CW'(1);
            w_ok      = 1'b1;
         end
      end
      w_tgt_room  = RW'(w_tgt_row) * RW'(GRID_W) + RW'(w_tgt_col);
      w_moves_nx  = (r_moves == LIMIT_M) ? r_moves : r_moves + MW'(1);
      w_at_dragon = (w_tgt_room == DRAGON_R);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= PLAY;
         r_row   <= START_ROW;
         r_col   <= START_COL;
         r_room  <= START_R;
         r_sword <= 1'b0;
         r_lives <= 3'(LIVES);
         r_moves <= '0;
         r_win   <= 1'b0;
         r_die   <= 1'b0;
      end else begin
         case (r_state)
            PLAY: begin
               if (w_ok) begin
                  r_row   <= w_tgt_row;
                  r_col   <= w_tgt_col;
                  r_room  <= w_tgt_room;
                  r_moves <= w_moves_nx;
                  if (w_tgt_room == SWORD_R) r_sword <= 1'b1;
                  if (w_at_dragon) begin
                     if (r_sword) begin
                        r_state <= WON;
                        r_win   <= 1'b1;
                     end else begin
                        r_sword <= 1'b0;
                        r_lives <= r_lives - 3'd1;
                        if (r_lives == 3'd1) begin
                           r_state <= DEAD;
                           r_die   <= 1'b1;
                        end else begin
                           r_state <= RESPAWN;
                        end
                     end
                  end
`ifdef ADV_MOVE_LIMIT_EN
                  // Running out of moves kills, unless this very move slays the dragon.
                  if (w_moves_nx == LIMIT_M && !(w_at_dragon && r_sword)) begin
                     r_state <= DEAD;
                     r_die   <= 1'b1;
                  end
`endif
               end
            end
            RESPAWN: begin
               r_row   <= START_ROW;
               r_col   <= START_COL;
               r_room  <= START_R;
               r_state <= PLAY;
            end
            default: ;
         endcase
      end
   end

   assign room      = r_room;
   assign has_sword = r_sword;
   assign lives     = r_lives;
   assign moves     = r_moves;
   assign WIN       = r_win;
   assign DIE       = r_die;

endmodule

// File: tb/tb_adventure_maze.sv
// Bench for adventure_maze: two instances (default map, and dragon-at-3 / 4-move budget)
// checked every cycle against a room-index model, plus hand-computed literal checks.
module tb_adventure_maze;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic N = 1'b0, S = 1'b0, E = 1'b0, W = 1'b0;

   logic [3:0] room0, room1;
   logic       sword0, sword1, win0, win1, die0, die1;
   logic [2:0] lives0, lives1;
   logic [4:0] moves0;
   logic [2:0] moves1;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   adventure_maze dut0 (
      .clk(clk), .reset(reset), .N(N), .S(S), .E(E), .W(W),
      .room(room0), .has_sword(sword0), .lives(lives0), .moves(moves0),
      .WIN(win0), .DIE(die0)
   );

   adventure_maze #(.DRAGON_ROOM(3), .SWORD_ROOM(5), .MOVE_LIMIT(4)) dut1 (
      .clk(clk), .reset(reset), .N(N), .S(S), .E(E), .W(W),
      .room(room1), .has_sword(sword1), .lives(lives1), .moves(moves1),
      .WIN(win1), .DIE(die1)
   );

   // Model: game phase 0=playing, 1=respawning, 2=won, 3=dead.
   localparam int GW = 4, GH = 4, START = 0, SWORD = 5, LIVES_INIT = 3;
   int m_room[2], m_sword[2], m_lives[2], m_moves[2], m_win[2], m_die[2], m_ph[2];

   function automatic int p_dragon(int i);
      return (i == 0) ? 15 : 3;
   endfunction

   function automatic int p_limit(int i);
      return (i == 0) ? 31 : 4;
   endfunction

   function automatic void m_reset(int i);
      m_room[i] = START; m_sword[i] = 0; m_lives[i] = LIVES_INIT;
      m_moves[i] = 0; m_win[i] = 0; m_die[i] = 0; m_ph[i] = 0;
   endfunction

   function automatic void m_step(int i, int n, int s, int e, int w);
      int nr, nc, tgt;
      bit won;
      if (m_ph[i] == 1) begin
         m_room[i] = START;
         m_ph[i] = 0;
         return;
      end
      if (m_ph[i] != 0 || (n + s + e + w) != 1) return;
      nr = m_room[i] / GW - n + s;
      nc = m_room[i] % GW + e - w;
      if (nr < 0 || nr >= GH || nc < 0 || nc >= GW) return;
      tgt = nr * GW + nc;
      m_room[i] = tgt;
      if (m_moves[i] < p_limit(i)) m_moves[i]++;
      if (tgt == SWORD) m_sword[i] = 1;
      won = 1'b0;
      if (tgt == p_dragon(i)) begin
         if (m_sword[i] != 0) begin
            won = 1'b1; m_win[i] = 1; m_ph[i] = 2;
         end else begin
            m_sword[i] = 0;
            m_lives[i]--;
            if (m_lives[i] == 0) begin
               m_die[i] = 1; m_ph[i] = 3;
            end else begin
               m_ph[i] = 1;
            end
         end
      end
`ifdef ADV_MOVE_LIMIT_EN
      if (m_moves[i] == p_limit(i) && !won) begin
         m_die[i] = 1; m_ph[i] = 3;
      end
`endif
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (reset) m_reset(i);
         else m_step(i, int'(N), int'(S), int'(E), int'(W));
      end
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("d0_room",  32'(room0),  m_room[0]);
         chk("d0_sword", 32'(sword0), m_sword[0]);
         chk("d0_lives", 32'(lives0), m_lives[0]);
         chk("d0_moves", 32'(moves0), m_moves[0]);
         chk("d0_win",   32'(win0),   m_win[0]);
         chk("d0_die",   32'(die0),   m_die[0]);
         chk("d1_room",  32'(room1),  m_room[1]);
         chk("d1_sword", 32'(sword1), m_sword[1]);
         chk("d1_lives", 32'(lives1), m_lives[1]);
         chk("d1_moves", 32'(moves1), m_moves[1]);
         chk("d1_win",   32'(win1),   m_win[1]);
         chk("d1_die",   32'(die1),   m_die[1]);
         chk("d0_excl",  32'(win0 & die0), 0);
         chk("d1_excl",  32'(win1 & die1), 0);
      end
   end

   // Inputs change on the falling edge; returns at the next falling edge.
   task automatic step(input logic [3:0] nsew);
      {N, S, E, W} = nsew;
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(4'b0000);
      reset = 1'b0;
   endtask

   localparam logic [3:0] DN = 4'b1000, DS = 4'b0100, DE = 4'b0010, DW = 4'b0001;

   task automatic dragon_run();
      step(DE); step(DE); step(DE); step(DS); step(DS); step(DS);
   endtask

   initial begin
      @(negedge clk);
      // Reset held two cycles with E asserted.
      reset = 1'b1;
      step(DE); step(DE);
      reset = 1'b0;
      chk("rst_room", 32'(room0), 0);
      chk("rst_lives", 32'(lives0), 3);
      chk("rst_sword", 32'(sword0), 0);
      chk("rst_moves", 32'(moves0), 0);
      chk("rst_windie", 32'({win0, die0}), 0);
      chk_en = 1'b1;

      step(DN);       chk("wall_n", 32'({room0, moves0}), 0);
      step(DW);       chk("wall_w", 32'({room0, moves0}), 0);
      step(DE);       chk("move_e_room", 32'(room0), 1); chk("move_e_moves", 32'(moves0), 1);
      step(DN | DE);  chk("multi_room", 32'(room0), 1); chk("multi_moves", 32'(moves0), 1);

      do_reset();
      step(DS); step(DE);
      chk("sword_room", 32'(room0), 5); chk("sword_got", 32'(sword0), 1);
      step(DE); step(DE); step(DS); step(DS);
      chk("win_room", 32'(room0), 15); chk("win_flag", 32'(win0), 1);
      chk("win_moves", 32'(moves0), 6); chk("win_die", 32'(die0), 0);
      step(DS); step(DW); step(DS);
      chk("won_hold", 32'({room0, win0, moves0}), {4'd15, 1'b1, 5'd6});

      do_reset();
      dragon_run();
      chk("drg_room", 32'(room0), 15); chk("drg_lives", 32'(lives0), 2);
      step(4'b0000);
      chk("respawn_room", 32'(room0), 0); chk("respawn_moves", 32'(moves0), 6);
      dragon_run(); step(4'b0000);
      chk("drg2_lives", 32'(lives0), 1); chk("drg2_moves", 32'(moves0), 12);
      dragon_run();
      chk("dead_lives", 32'(lives0), 0); chk("dead_flag", 32'(die0), 1);
      step(DN);
      chk("dead_room", 32'(room0), 15);
      do_reset();
      chk("rst_clears_die", 32'(die0), 0);

      // Second instance: dragon at room 3.
      do_reset();
      step(DE); step(DE); step(DE);
      chk("d1_drg_lives", 32'(lives1), 2); chk("d1_drg_sword", 32'(sword1), 0);
      step(4'b0000);
      chk("d1_respawn_room", 32'(room1), 0);

      do_reset();
      step(DS); step(DE);
      chk("mid_sword", 32'(sword0), 1);
      do_reset();
      chk("mid_reset", 32'({room0, sword0, moves0}), 0);

      // Four-move budget on the second instance.
      do_reset();
      step(DE); step(DS); step(DW); step(DN);
      chk("ml_room", 32'(room1), 0);
`ifdef ADV_MOVE_LIMIT_EN
      chk("ml_die", 32'(die1), 1);
`else
      chk("ml_moves", 32'(moves1), 4);
      chk("ml_nodie", 32'(die1), 0);
`endif

      for (int k = 0; k < 4000; k++) begin
         logic [3:0] v;
         reset = ($urandom_range(0, 99) < 2);
         if ($urandom_range(0, 3) != 0) v = 4'(1 << $urandom_range(0, 3));
         else v = 4'($urandom_range(0, 15));
         step(v);
      end
      reset = 1'b0;
      step(4'b0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
